gpio_serial_cfg_bank: RTL and testbench
=======================================

// Module: gpio_serial_cfg_bank
// PURPOSE
//  Parametrised PS->PL serial configuration bank driven by the GPIO control bus.
//  Synchronises the GPIO bus and shifts shared sdata into NUM_REGS shadow registers, one per GPIO shift-clock line.
//  Copies all shadows atomically into active registers on a commit-line rising edge, and pulses an update strobe.
//  Flags overflowed and partially loaded registers. Sits between the PS GPIO and the DAC/ADC controllers.
// PARAMETERS
//  GPIO_W      16    width of GPIO control bus
//  NUM_REGS    8     number of configuration registers
//  REG_W       32    width of each configuration register
//  SYNC_STAGES 2     synchroniser flops per GPIO bit (>=2)
//  SDATA_BIT   0     GPIO bit carrying serial data
//  COMMIT_BIT  14    GPIO bit whose rising edge commits shadows to active
//  CLK_MAP     {8'd..} NUM_REGS*8 packed; byte i = GPIO bit index of shift clock for reg i
// PORTS
//  clk          in   1              fabric clock; all logic on rising edge
//  rst_n        in   1              synchronous reset, active-low
//  gpio_in      in   GPIO_W         asynchronous GPIO bus from PS
//  cfg_active   out  NUM_REGS*REG_W committed values; reg i at [i*REG_W +: REG_W]
//  cfg_update   out  1              one-cycle pulse, cycle cfg_active changes
//  cfg_dirty    out  NUM_REGS       reg i shadow shifted since last commit
//  err_overflow out  NUM_REGS       sticky: >REG_W bits shifted into reg i since last commit
//  err_partial  out  NUM_REGS       latched at commit: reg i had 1..REG_W-1 bits shifted
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): shadows, cfg_active, bit counters, sync/edge flops, all outputs = 0.
//  Sync: every GPIO bit passes SYNC_STAGES flops, then one history flop. rise[b] = sync[b] & ~hist[b].
//  Shift: on rise[CLK_MAP[i]], shadow[i] <= {shadow[i][REG_W-2:0], sync[SDATA_BIT]} (MSB first).
//   sdata is sampled through an identical sync path, so the bit present at the PS clock rise is captured.
//   sdata must be stable for >= SYNC_STAGES+1 clk cycles around the PS shift-clock rise.
//  Latency: a GPIO rise updates the shadow on edge SYNC_STAGES+2 after the pin changes.
//   Commit has the same latency to cfg_active/cfg_update.
//  Bit counter per reg: width $clog2(REG_W+2), increments per shift, saturates at REG_W+1.
//   When it reaches REG_W+1, err_overflow[i] is set.
//  Commit (rise[COMMIT_BIT]), in one cycle:
//   cfg_active <= all shadows; cfg_update=1.
//   err_partial[i] <= (cnt[i]!=0 && cnt[i]<REG_W).
//   Bit counters, cfg_dirty and err_overflow clear. Shadows are retained, not cleared.
//  Simultaneous shift + commit on the same cycle:
//   Commit takes the pre-shift shadow value.
//   The shift is then applied and counted as bit 1 of the next load; cfg_dirty[i]=1.
//  Multiple clock lines rising together: each mapped reg shifts the same sdata bit independently.
//  CLK_MAP entries equal to SDATA_BIT or COMMIT_BIT, or duplicated, are illegal; flag with elaboration $error.
//  Commit with no dirty regs: cfg_active rewritten with unchanged values; cfg_update still pulses.
//  Reset mid-shift: everything zeroed; the partial load is lost and the next load starts at count 0.
//  Overflow does not block shifting; the shadow keeps the last REG_W bits.
// STRUCTURE
//  rfsoc_config package carries the GPIO bit-index localparams, gpio_bus_width and config_reg_width.
//   Top-level CLK_MAP, COMMIT_BIT and REG_W defaults are taken from it.
//  Add localparam commit_clk = 14 to the rfsoc_config GPIO bus definitions.
//  Sub-module gpio_edge_sync (params W, STAGES): synchroniser + history flop; outputs sync[W] and rise[W].
//  Top: gpio_edge_sync plus a generate loop over NUM_REGS holding shadow, counter and flags, then the commit logic.
// TESTING
//  1 Reset: hold rst_n=0 with gpio_in toggling -> all outputs 0; first cycle after release still 0.
//  2 Load 0xDEADBEEF MSB-first into reg 2, then commit:
//    cfg_active[2]=0xDEADBEEF; cfg_update high exactly 1 cycle, SYNC_STAGES+2 edges after the commit rise.
//    Other regs 0; err_partial=0.
//  3 Shift 20 bits into reg 0, then commit -> err_partial[0]=1.
//    cfg_active[0] = the 20 bits right-aligned; dirty cleared.
//  4 Shift 33 bits into reg 1 -> err_overflow[1]=1 before commit.
//    After commit, active = last 32 bits and err_overflow[1]=0.
//  5 Drive the reg 3 clock and commit rises on the same gpio_in update:
//    active[3] = pre-shift shadow; next shadow shifted; cfg_dirty[3]=1.
//  6 Assert rst_n=0 after 10 of 32 bits into reg 4 -> all cleared.
//    A full 32-bit reload plus commit then yields the exact word with err_partial[4]=0.

Source files
------------

// File: rtl/rfsoc_config.sv
// Shared RFSoC PS<->PL configuration constants.
// GPIO bit assignments and widths for the serial config bank.
package rfsoc_config;

  localparam int gpio_bus_width   = 16;
  localparam int config_reg_width = 32;
  localparam int num_cfg_regs     = 8;

  localparam int sdata_bit  = 0;
  localparam int dac0_clk   = 1;
  localparam int dac1_clk   = 2;
  localparam int dac2_clk   = 3;
  localparam int dac3_clk   = 4;
  localparam int adc0_clk   = 5;
  localparam int adc1_clk   = 6;
  localparam int adc2_clk   = 7;
  localparam int adc3_clk   = 8;
  localparam int commit_clk = 14;

  localparam logic [num_cfg_regs*8-1:0] clk_map_default = {
    8'(adc3_clk), 8'(adc2_clk), 8'(adc1_clk), 8'(adc0_clk),
    8'(dac3_clk), 8'(dac2_clk), 8'(dac1_clk), 8'(dac0_clk)
  };

endpackage

// File: rtl/gpio_serial_cfg_bank_sync.sv
// GPIO synchroniser with a history flop and registered rise detect.
// o_sync is delayed to line up with o_rise.
module gpio_edge_sync #(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_sync [STAGES];
  logic [W-1:0] r_hist;
  logic [W-1:0] r_rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) r_sync[s] <= '0;
      r_hist <= '0;
      r_rise <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_hist;
    end
  end

  assign o_sync = r_hist;
  assign o_rise = r_rise;

endmodule

// File: rtl/gpio_serial_cfg_bank.sv
// Serial configuration bank: GPIO shift clocks load shadow registers,
// a commit edge copies all shadows to the active outputs at once.
module gpio_serial_cfg_bank
  import rfsoc_config::*;
#(
  parameter int GPIO_W      = gpio_bus_width,
  parameter int NUM_REGS    = num_cfg_regs,
  parameter int REG_W       = config_reg_width,
  parameter int SYNC_STAGES = 2,
  parameter int SDATA_BIT   = sdata_bit,
  parameter int COMMIT_BIT  = commit_clk,
  parameter logic [NUM_REGS*8-1:0] CLK_MAP = clk_map_default
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [GPIO_W-1:0]         gpio_in,
  output logic [NUM_REGS*REG_W-1:0] cfg_active,
  output logic                      cfg_update,
  output logic [NUM_REGS-1:0]       cfg_dirty,
  output logic [NUM_REGS-1:0]       err_overflow,
  output logic [NUM_REGS-1:0]       err_partial
);

  localparam int CW = $clog2(REG_W + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(REG_W);
  localparam logic [CW-1:0] CNT_MAX  = CW'(REG_W + 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  logic [GPIO_W-1:0] w_sync;
  logic [GPIO_W-1:0] w_rise;
  logic              w_commit;
  logic              w_sdata;

  gpio_edge_sync #(
    .W      (GPIO_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (gpio_in),
    .o_sync (w_sync),
    .o_rise (w_rise)
  );

  assign w_commit = w_rise[COMMIT_BIT];
  assign w_sdata  = w_sync[SDATA_BIT];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam int CB = int'(CLK_MAP[i*8 +: 8]);

    if (CB >= GPIO_W) begin : g_e_range
      $error("CLK_MAP entry %0d out of range", i);
    end
    if (CB == SDATA_BIT || CB == COMMIT_BIT) begin : g_e_clash
      $error("CLK_MAP entry %0d hits sdata/commit", i);
    end
    for (genvar j = 0; j < i; j++) begin : g_dup
      if (int'(CLK_MAP[j*8 +: 8]) == CB) begin : g_e_dup
        $error("CLK_MAP entries %0d and %0d equal", j, i);
      end
    end

    logic             w_shift;
    logic [REG_W-1:0] r_shadow;
    logic [REG_W-1:0] r_active;
    logic [CW-1:0]    r_cnt;
    logic             r_dirty;
    logic             r_ovf;
    logic             r_part;

    assign w_shift = w_rise[CB % GPIO_W];

    // Commit reads the pre-shift shadow; a coincident shift starts the next load.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_shadow <= '0;
        r_active <= '0;
        r_cnt    <= '0;
        r_dirty  <= 1'b0;
        r_ovf    <= 1'b0;
        r_part   <= 1'b0;
      end else begin
        if (w_shift) r_shadow <= {r_shadow[REG_W-2:0], w_sdata};
        if (w_commit) begin
          r_active <= r_shadow;
          r_part   <= (r_cnt != '0) && (r_cnt < CNT_FULL);
          r_cnt    <= w_shift ? CW'(1) : '0;
          r_dirty  <= w_shift;
          r_ovf    <= 1'b0;
        end else if (w_shift) begin
          r_dirty <= 1'b1;
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CNT_FULL) r_ovf <= 1'b1;
        end
      end
    end

    assign cfg_active[i*REG_W +: REG_W] = r_active;
    assign cfg_dirty[i]    = r_dirty;
    assign err_overflow[i] = r_ovf;
    assign err_partial[i]  = r_part;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cfg_update <= 1'b0;
    else        cfg_update <= w_commit;
  end

endmodule

// File: tb/tb_gpio_serial_cfg_bank.sv
// Directed bench for gpio_serial_cfg_bank.
// Table of load/commit vectors plus hand sequences for corner cases.
module tb_gpio_serial_cfg_bank;

  localparam int NR = 8;
  localparam int RW = 32;
  localparam int CB = 14;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [15:0]     gpio_in;
  logic [NR*RW-1:0] cfg_active;
  logic            cfg_update;
  logic [NR-1:0]   cfg_dirty;
  logic [NR-1:0]   err_overflow;
  logic [NR-1:0]   err_partial;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpio_serial_cfg_bank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gpio_in      (gpio_in),
    .cfg_active   (cfg_active),
    .cfg_update   (cfg_update),
    .cfg_dirty    (cfg_dirty),
    .err_overflow (err_overflow),
    .err_partial  (err_partial)
  );

  typedef struct {
    int          r;
    int          nbits;
    logic [63:0] data;
    logic [31:0] exp_act;
    logic [7:0]  exp_part;
    logic [7:0]  exp_ovf;
  } vec_t;

  vec_t        vt [4];
  logic [31:0] mdl [NR];

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(int r, logic b);
    gpio_in[0] = b;
    wait_n(4);
    gpio_in[r+1] = 1'b1;
    wait_n(4);
    gpio_in[r+1] = 1'b0;
    wait_n(4);
  endtask

  task automatic load(int r, int nb, logic [63:0] d);
    for (int k = nb - 1; k >= 0; k--) shift_bit(r, d[k]);
  endtask

  task automatic do_commit(string nm);
    gpio_in[CB] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk(nm, 64'(cfg_update), 64'(k == 4));
    end
    @(negedge clk);
    gpio_in[CB] = 1'b0;
    wait_n(4);
  endtask

  task automatic chk_all_active(string nm);
    for (int r = 0; r < NR; r++)
      chk(nm, 64'(cfg_active[r*RW +: RW]), 64'(mdl[r]));
  endtask

  initial begin
    vt[0] = '{2, 32, 64'hDEADBEEF,    32'hDEADBEEF, 8'h00, 8'h00};
    vt[1] = '{0, 20, 64'hABCDE,       32'h000ABCDE, 8'h01, 8'h00};
    vt[2] = '{1, 33, 64'h1_1234_5678, 32'h12345678, 8'h00, 8'h02};
    vt[3] = '{7, 0,  64'h0,           32'h00000000, 8'h00, 8'h00};
    for (int r = 0; r < NR; r++) mdl[r] = '0;

    rst_n   = 1'b0;
    gpio_in = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      gpio_in = 16'($urandom);
    end
    @(posedge clk);
    #1;
    chk("rst_active", 64'(cfg_active == '0), 64'd1);
    chk("rst_flags", {cfg_update, cfg_dirty, err_overflow, err_partial}, 64'd0);
    @(negedge clk);
    gpio_in = '0;
    wait_n(1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_active", 64'(cfg_active == '0), 64'd1);
    chk("rel_flags", {cfg_update, cfg_dirty, err_overflow, err_partial}, 64'd0);
    wait_n(4);

    for (int v = 0; v < 4; v++) begin
      load(vt[v].r, vt[v].nbits, vt[v].data);
      chk("pre_dirty", 64'(cfg_dirty), (vt[v].nbits > 0) ? 64'(1 << vt[v].r) : 64'd0);
      chk("pre_ovf", 64'(err_overflow), 64'(vt[v].exp_ovf));
      do_commit("upd_lat");
      mdl[vt[v].r] = vt[v].exp_act;
      chk_all_active("active");
      chk("partial", 64'(err_partial), 64'(vt[v].exp_part));
      chk("post_dirty", 64'(cfg_dirty), 64'd0);
      chk("post_ovf", 64'(err_overflow), 64'd0);
    end

    load(3, 8, 64'hA5);
    chk("r3_dirty", 64'(cfg_dirty), 64'h08);
    gpio_in[0] = 1'b1;
    wait_n(4);
    gpio_in[4]  = 1'b1;
    gpio_in[CB] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk("sim_upd", 64'(cfg_update), 64'(k == 4));
    end
    mdl[3] = 32'hA5;
    chk_all_active("sim_active");
    chk("sim_dirty", 64'(cfg_dirty), 64'h08);
    chk("sim_part", 64'(err_partial), 64'h08);
    @(negedge clk);
    gpio_in[4]  = 1'b0;
    gpio_in[CB] = 1'b0;
    wait_n(4);
    do_commit("sim2_upd");
    mdl[3] = 32'h14B;
    chk_all_active("sim2_active");
    chk("sim2_part", 64'(err_partial), 64'h08);
    chk("sim2_dirty", 64'(cfg_dirty), 64'd0);

    load(4, 10, 64'h2AB);
    chk("r4_dirty", 64'(cfg_dirty), 64'h10);
    rst_n = 1'b0;
    wait_n(2);
    rst_n = 1'b1;
    wait_n(1);
    for (int r = 0; r < NR; r++) mdl[r] = '0;
    chk("mid_active", 64'(cfg_active == '0), 64'd1);
    chk("mid_flags", {cfg_dirty, err_overflow, err_partial}, 64'd0);
    wait_n(4);
    load(4, 32, 64'hCAFEF00D);
    chk("r4_ovf", 64'(err_overflow), 64'd0);
    do_commit("r4_upd");
    mdl[4] = 32'hCAFEF00D;
    chk_all_active("r4_active");
    chk("r4_part", 64'(err_partial), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
